// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - decode-side push and RS-side issue signals of the issue queue
interface issue_queue_if #(
  parameter int WORD_SIZE = 32,
  parameter int REG_SIZE  = 5
);
  // decode side
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_unit;
  logic [REG_SIZE-1:0]  in_reg1;
  logic [REG_SIZE-1:0]  in_reg2;
  logic [REG_SIZE-1:0]  in_reg3;
  logic                 in_hasimm;
  logic [WORD_SIZE-1:0] in_imm;

  // reservation station side
  logic                 rs_busy;
  logic [2:0]           unit;
  logic [REG_SIZE-1:0]  reg1;
  logic [REG_SIZE-1:0]  reg2;
  logic [REG_SIZE-1:0]  reg3;
  logic                 hasimm;
  logic [WORD_SIZE-1:0] imm;
  logic                 enable;

  modport slave (
    input  in_valid, in_unit, in_reg1, in_reg2, in_reg3, in_hasimm, in_imm, rs_busy,
    output in_ready, unit, reg1, reg2, reg3, hasimm, imm, enable
  );

  modport master (
    output in_valid, in_unit, in_reg1, in_reg2, in_reg3, in_hasimm, in_imm, rs_busy,
    input  in_ready, unit, reg1, reg2, reg3, hasimm, imm, enable
  );
endinterface

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - in-order op FIFO between decode and the reservation station
module issue_queue #(
  parameter int WORD_SIZE = 32,
  parameter int REG_SIZE  = 5,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  issue_queue_if.slave               bus,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       illegal
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 3 + 3*REG_SIZE + 1 + WORD_SIZE;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          ready;
  logic          legal;
  logic          push;
  logic          pop;

  // Readiness looks only at occupancy, so a full queue refuses a push even
  // when the same edge pops; decode holds its fields until accepted.
  assign ready        = (count != CW'(DEPTH));
  assign bus.in_ready = ready;
  assign legal        = (bus.in_unit <= 3'b100);
  assign push         = bus.in_valid & ready & ~flush & legal;
  assign pop          = ~flush & (count != '0) & ~bus.rs_busy;

  // Entry storage: written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= {bus.in_unit, bus.in_reg1, bus.in_reg2, bus.in_reg3,
                    bus.in_hasimm, bus.in_imm};
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue register: the head entry is latched with a one-cycle enable; fields
  // keep the last issued op while nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.unit   <= '0;
      bus.reg1   <= '0;
      bus.reg2   <= '0;
      bus.reg3   <= '0;
      bus.hasimm <= 1'b0;
      bus.imm    <= '0;
      bus.enable <= 1'b0;
    end else begin
      bus.enable <= pop;
      if (pop) begin
        {bus.unit, bus.reg1, bus.reg2, bus.reg3, bus.hasimm, bus.imm} <= mem[head];
      end
    end
  end

  // Illegal unit codes are reported even during flush, since the op was
  // still presented and rejected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal <= 1'b0;
    else        illegal <= bus.in_valid & ready & ~legal;
  end
endmodule
